// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : display_scan_ctrl
//  Description : Four-digit multiplexed seven-segment scan controller.
//                Cycles through the digits with a guard interval, buffers
//                new values in a shadow register and commits them to the
//                display only at frame boundaries. Optionally blanks
//                leading zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2,
    parameter int BLANK_LZ    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    output logic [3:0]  bin,
    output logic [3:0]  an,
    output logic        frame_tick,
    output logic        value_err
);

    localparam int                 c_PRE_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(REFRESH_DIV - 1);
    localparam logic [c_PRE_W-1:0] c_GUARD    = c_PRE_W'(GUARD);
    localparam logic [c_PRE_W-1:0] c_PRE_ONE  = c_PRE_W'(1);
    localparam logic [3:0]         c_BLANK    = 4'hF;

    logic [c_PRE_W-1:0] r_pre;
    logic [1:0]         r_idx;
    logic [15:0]        r_shd;
    logic [15:0]        r_dsp;
    logic               r_err;

    logic               w_slot_end;
    logic               w_frame_end;
    logic               w_val_bad;
    logic [3:0]         w_nib;
    logic [3:0]         w_lz;

    assign w_slot_end  = (r_pre == c_PRE_LAST);
    assign w_frame_end = w_slot_end && (r_idx == 2'd3);

    // Any BCD digit above 9 in the incoming value is illegal.
    assign w_val_bad = (value[15:12] > 4'd9) || (value[11:8] > 4'd9) ||
                       (value[7:4]   > 4'd9) || (value[3:0]  > 4'd9);

    // Prescaler and digit index: free-running scan, independent of load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= 2'd0;
        end else if (w_slot_end) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + c_PRE_ONE;
        end
    end

    // Shadow capture on load; display commit only at the frame boundary,
    // with a coincident load bypassing the shadow straight to the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shd <= 16'h0000;
            r_dsp <= 16'h0000;
        end else begin
            if (load) begin
                r_shd <= value;
            end
            if (w_frame_end) begin
                r_dsp <= load ? value : r_shd;
            end
        end
    end

    // Sticky illegal-digit flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (load && w_val_bad) begin
            r_err <= 1'b1;
        end
    end

    // Select the display nibble for the digit currently being scanned.
    always_comb begin
        w_nib = r_dsp[3:0];
        case (r_idx)
            2'd0:    w_nib = r_dsp[3:0];
            2'd1:    w_nib = r_dsp[7:4];
            2'd2:    w_nib = r_dsp[11:8];
            default: w_nib = r_dsp[15:12];
        endcase
    end

    // Leading-zero mask: a digit is blank when it and every higher digit is 0.
    generate
        if (BLANK_LZ != 0) begin : g_lz
            assign w_lz[3] = (r_dsp[15:12] == 4'd0);
            assign w_lz[2] = w_lz[3] && (r_dsp[11:8] == 4'd0);
            assign w_lz[1] = w_lz[2] && (r_dsp[7:4]  == 4'd0);
            assign w_lz[0] = 1'b0;
        end else begin : g_no_lz
            assign w_lz = 4'b0000;
        end
    endgenerate

    // Anode and nibble decode from the registered scan state.
    always_comb begin
        an  = 4'b1111;
        bin = w_nib;
        if (r_pre >= c_GUARD) begin
            an = ~(4'b0001 << r_idx);
        end
        if ((w_nib > 4'd9) || w_lz[r_idx]) begin
            bin = c_BLANK;
        end
    end

    assign frame_tick = w_frame_end;
    assign value_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scan_ctrl
//  Description : Scoreboard bench for display_scan_ctrl (REFRESH_DIV=4,
//                GUARD=1). Two instances share stimulus: one with leading
//                zero blanking, one without.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  bin_a, an_a, bin_b, an_b;
    logic        ft_a, err_a, ft_b, err_b;

    display_scan_ctrl #(.REFRESH_DIV(4), .GUARD(1), .BLANK_LZ(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .bin(bin_a), .an(an_a), .frame_tick(ft_a), .value_err(err_a)
    );

    display_scan_ctrl #(.REFRESH_DIV(4), .GUARD(1), .BLANK_LZ(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .bin(bin_b), .an(an_b), .frame_tick(ft_b), .value_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        logic [3:0] an;
        logic [3:0] bin_a;
        logic [3:0] bin_b;
        logic       ft;
        logic       err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   exp_err;

    // Hand-computed digits per frame, slot 0..3 (blanking / no blanking).
    // f0: 0000  f1: 1234  f2: 0070  f3: 12A4  f4: 0005  f5: 5678  f6,f7: 0000
    logic [3:0] tbl_a [0:7][0:3] = '{
        '{4'h0, 4'hF, 4'hF, 4'hF},
        '{4'h4, 4'h3, 4'h2, 4'h1},
        '{4'h0, 4'h7, 4'hF, 4'hF},
        '{4'h4, 4'hF, 4'h2, 4'h1},
        '{4'h5, 4'hF, 4'hF, 4'hF},
        '{4'h8, 4'h7, 4'h6, 4'h5},
        '{4'h0, 4'hF, 4'hF, 4'hF},
        '{4'h0, 4'hF, 4'hF, 4'hF}
    };
    logic [3:0] tbl_b [0:7][0:3] = '{
        '{4'h0, 4'h0, 4'h0, 4'h0},
        '{4'h4, 4'h3, 4'h2, 4'h1},
        '{4'h0, 4'h7, 4'h0, 4'h0},
        '{4'h4, 4'hF, 4'h2, 4'h1},
        '{4'h5, 4'h0, 4'h0, 4'h0},
        '{4'h8, 4'h7, 4'h6, 4'h5},
        '{4'h0, 4'h0, 4'h0, 4'h0},
        '{4'h0, 4'h0, 4'h0, 4'h0}
    };
    logic [3:0] an_slot [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Load schedule: cycle, value, illegal-digit flag.
    int         ld_cyc [0:6] = '{5, 31, 36, 50, 51, 70, 85};
    logic [15:0] ld_val [0:6] = '{16'h1234, 16'h0070, 16'h12A4, 16'h0001,
                                  16'h0005, 16'h5678, 16'h4321};
    bit         ld_bad [0:6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    task automatic push_exp(input int tag, input logic [3:0] e_an,
                            input logic [3:0] e_ba, input logic [3:0] e_bb,
                            input logic e_ft, input logic e_err);
        exp_t e;
        e.tag   = tag;
        e.an    = e_an;
        e.bin_a = e_ba;
        e.bin_b = e_bb;
        e.ft    = e_ft;
        e.err   = e_err;
        sb_q.push_back(e);
    endtask

    task automatic run_scan(input int ncyc, input int fbase, input bit use_loads, input int tag_base);
        int pre, idx, f;
        bit bad_now;
        logic [3:0] e_an;
        for (int c = 0; c < ncyc; c++) begin
            pre     = c % 4;
            idx     = (c / 4) % 4;
            f       = fbase + c / 16;
            load    = 1'b0;
            value   = 16'h0000;
            bad_now = 1'b0;
            if (use_loads) begin
                for (int k = 0; k < 7; k++) begin
                    if (ld_cyc[k] == c) begin
                        load    = 1'b1;
                        value   = ld_val[k];
                        bad_now = ld_bad[k];
                    end
                end
            end
            e_an = (pre == 0) ? 4'b1111 : an_slot[idx];
            push_exp(tag_base + c, e_an, tbl_a[f][idx], tbl_b[f][idx],
                     (pre == 3) && (idx == 3), exp_err);
            @(posedge clk);
            #1;
            if (bad_now) exp_err = 1'b1;
        end
        load  = 1'b0;
        value = 16'h0000;
    endtask

    // Monitor: compare every presented cycle against the scoreboard head.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            n_checks++;
            if ({an_a, bin_a, ft_a, err_a} === {mon_e.an, mon_e.bin_a, mon_e.ft, mon_e.err})
                n_pass++;
            else
                $display("FAIL blank_dut tag=%0d: got an=%b bin=%h ft=%b err=%b, want an=%b bin=%h ft=%b err=%b",
                         mon_e.tag, an_a, bin_a, ft_a, err_a, mon_e.an, mon_e.bin_a, mon_e.ft, mon_e.err);
            n_checks++;
            if ({an_b, bin_b, ft_b, err_b} === {mon_e.an, mon_e.bin_b, mon_e.ft, mon_e.err})
                n_pass++;
            else
                $display("FAIL noblank_dut tag=%0d: got an=%b bin=%h ft=%b err=%b, want an=%b bin=%h ft=%b err=%b",
                         mon_e.tag, an_b, bin_b, ft_b, err_b, mon_e.an, mon_e.bin_b, mon_e.ft, mon_e.err);
        end
    end

    initial begin
        rst_n   = 1'b0;
        load    = 1'b0;
        value   = 16'h0000;
        exp_err = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            push_exp(1000 + i, 4'b1111, 4'h0, 4'h0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        run_scan(89, 0, 1'b1, 0);
        // Mid-slot reset during slot 2 while 5678 is displayed.
        rst_n   = 1'b0;
        exp_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_exp(2000 + i, 4'b1111, 4'h0, 4'h0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        run_scan(32, 6, 1'b0, 3000);
        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0)
            n_pass++;
        else
            $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (legal range 4..2^20).
REQ-002 SHALL have parameter GUARD, default 2, leading cycles of each slot with all anodes off (legal range 1..REFRESH_DIV-2).
REQ-003 SHALL have parameter BLANK_LZ, default 1, where 1 enables leading-zero blanking.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port load, input, 1, a single-cycle strobe that captures value.
REQ-008 SHALL have port value, input, 16, four BCD digits, [15:12] = digit3 (most significant), [3:0] = digit0.
REQ-009 SHALL have port bin, output, 4, the nibble for the downstream seven-segment decoder, where 4'hF means blank.
REQ-010 SHALL have port an, output, 4, active-low one-hot digit enable, an[k] = digit k.
REQ-011 SHALL have port frame_tick, output, 1, a one-cycle pulse on the cycle the display register updates.
REQ-012 SHALL have port value_err, output, 1, a sticky flag for a loaded nibble greater than 9.

Function
REQ-013 SHALL keep a prescaler pre counting 0..REFRESH_DIV-1; at the terminal count, pre->0 and digit index idx->(idx+1) mod 4.
REQ-014 SHALL capture value into shadow register shd on any cycle where load=1; back-to-back loads keep the last one.
REQ-015 SHALL copy shd into display register dsp only at the frame boundary, defined as pre=REFRESH_DIV-1 and idx=3, and assert frame_tick for exactly that cycle.
REQ-016 SHALL, when load and the frame boundary fall in the same cycle, write value directly into dsp (bypass), and also into shd.
REQ-017 SHALL drive an=4'b1111 while pre<GUARD, else an = ~(4'b0001<<idx); an and bin are combinational decodes of registered pre, idx, dsp.
REQ-018 SHALL drive bin = dsp nibble[idx], except 4'hF when the nibble is greater than 9 or the digit is a blanked leading zero.
REQ-019 SHALL, with BLANK_LZ=1, treat digit k (k=3..1) as a leading zero when it and all higher digits of dsp equal 0; digit0 is never blanked.
REQ-020 SHALL, with BLANK_LZ=0, apply no zero blanking.
REQ-021 SHALL set value_err when load=1 and any value nibble is greater than 9; it stays set until reset (no other clear).
REQ-022 SHALL NOT let load alter pre, idx or the scan timing.

Reset
REQ-023 SHALL, while rst_n=0, hold pre=0, idx=0, shd=0, dsp=0, value_err=0, frame_tick=0, so an=4'b1111 and bin=4'h0.
REQ-024 SHALL start scanning on the first rising clk after rst_n deasserts, with slot 0 beginning at pre=0.
REQ-025 SHALL, when reset is asserted mid-frame or mid-slot, immediately force the reset values and drop any pending shd content.

Verification (REFRESH_DIV=4, GUARD=1)
REQ-026 Reset, then run 16 cycles -> an repeats 1111,1110,1110,1110, then 1111,1101,... through 0111 per 4-cycle slot; bin=0 in slot 0 and F in slots 1-3 (BLANK_LZ=1).
REQ-027 load value=16'h1234 at cycle 5 -> no change in bin until frame_tick at cycle 15; the next frame shows bin 4,3,2,1 in slots 0..3.
REQ-028 load value=16'h0070 on the frame-boundary cycle -> bypass: the next frame shows bin 0,7,F,F; frame_tick=1 on that cycle.
REQ-029 load value=16'h12A4 -> value_err=1 and stays 1 after a later load of 16'h0001; slot 1 shows bin=F.
REQ-030 Assert rst_n=0 at slot 2 with dsp=16'h5678 -> an=1111, bin=0 immediately; after release, slot 0 shows 0 and value_err=0.
REQ-031 With BLANK_LZ=0 and value=16'h0005 -> bin 5,0,0,0 in slots 0..3.
